// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one side of a pipeline stage.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, freeze/flush control,
// an optional two-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
    parameter int                SKID       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_freeze,
    input  logic                    i_flush,
    pipe_stage_reg_if.slave         i_in,
    pipe_stage_reg_if.master        o_out,
    output logic [1:0]              o_occupancy,
    output logic [15:0]             o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] w_main_next;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_skid_next;
    logic [15:0]       r_stall_cnt;
    logic [15:0]       w_cnt_next;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_pop;

    // Entry valid bits are implied by the occupancy state.
    assign w_main_valid = (r_state != EMPTY);
    assign w_skid_valid = (r_state == TWO);
    assign w_out_valid  = w_main_valid && !i_freeze && !i_flush;

    generate
        if (SKID != 0) begin : g_skid
            // Registered-only ready: no path from out_ready to in_ready.
            assign w_in_ready = !w_skid_valid && !i_freeze && !i_flush && !rst;
        end else begin : g_noskid
            assign w_in_ready = (!w_main_valid || o_out.ready) && !i_freeze && !i_flush && !rst;
        end
    endgenerate

    assign w_accept = i_in.valid && w_in_ready;
    assign w_pop    = w_out_valid && o_out.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main_data <= RESET_DATA;
            r_skid_data <= RESET_DATA;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_main_data <= w_main_next;
            r_skid_data <= w_skid_next;
            r_stall_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main_data;
        w_skid_next  = r_skid_data;
        if (i_flush) begin
            w_state_next = EMPTY;
            w_main_next  = RESET_DATA;
            w_skid_next  = RESET_DATA;
        end else if (!i_freeze) begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ONE;
                        w_main_next  = i_in.data;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_next = i_in.data;
                    end else if (w_accept) begin
                        // Only reachable with the skid entry present.
                        if (SKID != 0) begin
                            w_state_next = TWO;
                            w_skid_next  = i_in.data;
                        end
                    end else if (w_pop) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_state_next = ONE;
                        w_main_next  = r_skid_data;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        w_cnt_next = r_stall_cnt;
        if (w_main_valid && !o_out.ready && !i_freeze && !i_flush && (r_stall_cnt != 16'hFFFF)) begin
            w_cnt_next = r_stall_cnt + 16'd1;
        end
    end

    assign i_in.ready   = w_in_ready;
    assign o_out.valid  = w_out_valid;
    assign o_out.data   = r_main_data;
    assign o_occupancy  = r_state;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg in skid (dut_a) and
// single-entry (dut_b) configurations.
module tb_pipe_stage_reg;

    localparam int          DW = 16;
    localparam logic [15:0] RD = 16'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_freeze, a_flush, b_freeze, b_flush;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_stall, b_stall;

    pipe_stage_reg_if #(.DATA_W(DW)) a_in ();
    pipe_stage_reg_if #(.DATA_W(DW)) a_out ();
    pipe_stage_reg_if #(.DATA_W(DW)) b_in ();
    pipe_stage_reg_if #(.DATA_W(DW)) b_out ();

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RD), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .i_freeze(a_freeze), .i_flush(a_flush),
        .i_in(a_in), .o_out(a_out), .o_occupancy(a_occ), .o_stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RD), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .i_freeze(b_freeze), .i_flush(b_flush),
        .i_in(b_in), .o_out(b_out), .o_occupancy(b_occ), .o_stall_cnt(b_stall)
    );

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        frz;
        logic        fl;
        logic        ir;
        logic        ov;
        logic [15:0] dat;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;

    vec_t va [30];
    vec_t vb [11];

    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(logic iv, logic [15:0] d, logic ordy, logic frz, logic fl,
                                logic ir, logic ov, logic [15:0] dat, logic [1:0] occ,
                                logic [15:0] st);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.frz = frz; v.fl = fl;
        v.ir = ir; v.ov = ov; v.dat = dat; v.occ = occ; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int dut, input vec_t v);
        if (dut == 0) begin
            a_in.valid = v.iv; a_in.data = v.d; a_out.ready = v.ordy;
            a_freeze = v.frz; a_flush = v.fl;
        end else begin
            b_in.valid = v.iv; b_in.data = v.d; b_out.ready = v.ordy;
            b_freeze = v.frz; b_flush = v.fl;
        end
    endtask

    // Drives one vector, checks outputs at the falling edge, then crosses the rising edge.
    task automatic apply(input int dut, input int row, input vec_t v);
        string tag;
        tag = $sformatf("%s[%0d]", (dut == 0) ? "skid" : "noskid", row);
        drive(dut, v);
        @(negedge clk);
        if (dut == 0) begin
            chk({tag, " in_ready"},  {31'd0, a_in.ready},  {31'd0, v.ir});
            chk({tag, " out_valid"}, {31'd0, a_out.valid}, {31'd0, v.ov});
            chk({tag, " out_data"},  {16'd0, a_out.data},  {16'd0, v.dat});
            chk({tag, " occupancy"}, {30'd0, a_occ},       {30'd0, v.occ});
            chk({tag, " stall_cnt"}, {16'd0, a_stall},     {16'd0, v.st});
        end else begin
            chk({tag, " in_ready"},  {31'd0, b_in.ready},  {31'd0, v.ir});
            chk({tag, " out_valid"}, {31'd0, b_out.valid}, {31'd0, v.ov});
            chk({tag, " out_data"},  {16'd0, b_out.data},  {16'd0, v.dat});
            chk({tag, " occupancy"}, {30'd0, b_occ},       {30'd0, v.occ});
            chk({tag, " stall_cnt"}, {16'd0, b_stall},     {16'd0, v.st});
        end
        $display("%s iv=%0b d=%h ordy=%0b frz=%0b fl=%0b", tag, v.iv, v.d, v.ordy, v.frz, v.fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            iv d      ordy frz fl  ir ov dat     occ st
        // stream 1..8
        va[0]  = mk(1, 16'h1, 1, 0, 0,   1, 0, RD,     0, 0);
        for (int k = 1; k < 8; k++)
            va[k] = mk(1, 16'(k + 1), 1, 0, 0, 1, 1, 16'(k), 1, 0);
        va[8]  = mk(0, 16'h0, 1, 0, 0,   1, 1, 16'h8,  1, 0);
        va[9]  = mk(0, 16'h0, 0, 0, 0,   1, 0, 16'h8,  0, 0);
        // back-pressure fills both entries
        va[10] = mk(1, 16'hA, 0, 0, 0,   1, 0, 16'h8,  0, 0);
        va[11] = mk(1, 16'hB, 0, 0, 0,   1, 1, 16'hA,  1, 0);
        va[12] = mk(1, 16'hC, 0, 0, 0,   0, 1, 16'hA,  2, 1);
        va[13] = mk(0, 16'h0, 0, 0, 0,   0, 1, 16'hA,  2, 2);
        va[14] = mk(0, 16'h0, 1, 0, 0,   0, 1, 16'hA,  2, 3);
        va[15] = mk(0, 16'h0, 1, 0, 0,   1, 1, 16'hB,  1, 3);
        va[16] = mk(0, 16'h0, 1, 0, 0,   1, 0, 16'hB,  0, 3);
        // freeze with 0x55 held
        va[17] = mk(1, 16'h55, 0, 0, 0,  1, 0, 16'hB,  0, 3);
        va[18] = mk(1, 16'h66, 1, 1, 0,  0, 0, 16'h55, 1, 3);
        va[19] = mk(1, 16'h66, 1, 1, 0,  0, 0, 16'h55, 1, 3);
        va[20] = mk(1, 16'h66, 1, 1, 0,  0, 0, 16'h55, 1, 3);
        va[21] = mk(0, 16'h0, 1, 0, 0,   1, 1, 16'h55, 1, 3);
        va[22] = mk(0, 16'h0, 0, 0, 0,   1, 0, 16'h55, 0, 3);
        // flush together with freeze while full
        va[23] = mk(1, 16'h1, 0, 0, 0,   1, 0, 16'h55, 0, 3);
        va[24] = mk(1, 16'h2, 0, 0, 0,   1, 1, 16'h1,  1, 3);
        va[25] = mk(1, 16'h3, 0, 1, 1,   0, 0, 16'h1,  2, 4);
        va[26] = mk(0, 16'h0, 1, 0, 0,   1, 0, RD,     0, 4);
        va[27] = mk(1, 16'h9, 1, 0, 0,   1, 0, RD,     0, 4);
        va[28] = mk(0, 16'h0, 1, 0, 0,   1, 1, 16'h9,  1, 4);
        va[29] = mk(0, 16'h0, 0, 0, 0,   1, 0, 16'h9,  0, 4);

        // single-entry mode, out_ready toggling
        vb[0]  = mk(1, 16'h11, 1, 0, 0,  1, 0, RD,     0, 0);
        vb[1]  = mk(1, 16'h12, 0, 0, 0,  0, 1, 16'h11, 1, 0);
        vb[2]  = mk(1, 16'h12, 1, 0, 0,  1, 1, 16'h11, 1, 1);
        vb[3]  = mk(1, 16'h13, 0, 0, 0,  0, 1, 16'h12, 1, 1);
        vb[4]  = mk(1, 16'h13, 1, 0, 0,  1, 1, 16'h12, 1, 2);
        vb[5]  = mk(1, 16'h14, 0, 0, 0,  0, 1, 16'h13, 1, 2);
        vb[6]  = mk(1, 16'h14, 1, 0, 0,  1, 1, 16'h13, 1, 3);
        vb[7]  = mk(0, 16'h0,  1, 0, 0,  1, 1, 16'h14, 1, 3);
        vb[8]  = mk(0, 16'h0,  0, 0, 0,  1, 0, 16'h14, 0, 3);
        vb[9]  = mk(1, 16'h15, 1, 1, 0,  0, 0, 16'h14, 0, 3);
        vb[10] = mk(0, 16'h0,  1, 0, 0,  1, 0, 16'h14, 0, 3);

        a_in.valid = 1'b1; a_in.data = 16'h77; a_out.ready = 1'b1;
        a_freeze = 1'b0; a_flush = 1'b0;
        b_in.valid = 1'b0; b_in.data = 16'h0; b_out.ready = 1'b0;
        b_freeze = 1'b0; b_flush = 1'b0;

        @(negedge clk);
        chk("reset in_ready",  {31'd0, a_in.ready},  32'd0);
        chk("reset out_valid", {31'd0, a_out.valid}, 32'd0);
        chk("reset out_data",  {16'd0, a_out.data},  {16'd0, RD});
        chk("reset occupancy", {30'd0, a_occ},       32'd0);
        chk("reset stall_cnt", {16'd0, a_stall},     32'd0);
        $display("reset check done");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 30; i++) apply(0, i, va[i]);

        // Long stall to saturate the counter.
        a_in.valid = 1'b1; a_in.data = 16'h7; a_out.ready = 1'b0;
        @(posedge clk);
        #1 a_in.valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat stall_cnt", {16'd0, a_stall},    32'h0000FFFF);
        chk("sat out_data",  {16'd0, a_out.data}, 32'h00000007);
        chk("sat occupancy", {30'd0, a_occ},      32'd1);
        $display("saturation stall_cnt=%h", a_stall);

        // Mid-cycle asynchronous reset.
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", {31'd0, a_out.valid}, 32'd0);
        chk("async in_ready",  {31'd0, a_in.ready},  32'd0);
        chk("async occupancy", {30'd0, a_occ},       32'd0);
        chk("async stall_cnt", {16'd0, a_stall},     32'd0);
        chk("async out_data",  {16'd0, a_out.data},  {16'd0, RD});
        $display("async reset pulse checked");
        #1 rst = 1'b0;
        a_in.valid = 1'b1; a_in.data = 16'h42; a_out.ready = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", {31'd0, a_in.ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post-rst out_valid", {31'd0, a_out.valid}, 32'd1);
        chk("post-rst out_data",  {16'd0, a_out.data},  32'h00000042);
        $display("first accept after reset: data=%h", a_out.data);
        a_in.valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) apply(1, i, vb[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
